// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control block: FSM states, instruction field
// positions, ALU comp opcodes and the jump-condition helper.
package hack_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StMemRd = 2'd2,
    StMemWr = 2'd3
  } state_e;

  // Instruction word field positions
  localparam int unsigned InstrTypeBit = 15;
  localparam int unsigned ABit         = 12;
  localparam int unsigned CompMsb      = 11;
  localparam int unsigned CompLsb      = 6;
  localparam int unsigned DestMsb      = 5;
  localparam int unsigned DestLsb      = 3;
  localparam int unsigned JumpMsb      = 2;
  localparam int unsigned JumpLsb      = 0;

  // Bit indices inside the 3-bit dest and jump fields
  localparam int unsigned DestA  = 2;
  localparam int unsigned DestD  = 1;
  localparam int unsigned DestM  = 0;
  localparam int unsigned JumpLt = 2;
  localparam int unsigned JumpEq = 1;
  localparam int unsigned JumpGt = 0;

  // comp = {zx, nx, zy, ny, f, no}; y is A or M depending on the a bit
  localparam logic [5:0] CompZero      = 6'b101010;
  localparam logic [5:0] CompOne       = 6'b111111;
  localparam logic [5:0] CompNegOne    = 6'b111010;
  localparam logic [5:0] CompD         = 6'b001100;
  localparam logic [5:0] CompY         = 6'b110000;
  localparam logic [5:0] CompNotD      = 6'b001101;
  localparam logic [5:0] CompDPlusOne  = 6'b011111;
  localparam logic [5:0] CompYMinusOne = 6'b110010;
  localparam logic [5:0] CompDPlusY    = 6'b000010;
  localparam logic [5:0] CompDMinusY   = 6'b010011;
  localparam logic [5:0] CompDAndY     = 6'b000000;
  localparam logic [5:0] CompDOrY      = 6'b010101;

  function automatic logic jump_taken(input logic [2:0] jump, input logic ng, input logic zr);
    return (jump[JumpLt] & ng) | (jump[JumpEq] & zr) | (jump[JumpGt] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Fetch, data-memory and pc-control signals of the Hack CPU control block.
// master = control block, slave = ROM/RAM/pc environment.
interface hack_cpu_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] inM;
  logic        mem_ready;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic        readM;
  logic        pc_load;
  logic        pc_inc;
  logic [15:0] pc_in;

  modport master (
    input  instr, instr_valid, inM, mem_ready,
    output instr_ready, addressM, outM, writeM, readM, pc_load, pc_inc, pc_in
  );

  modport slave (
    output instr, instr_valid, inM, mem_ready,
    input  instr_ready, addressM, outM, writeM, readM, pc_load, pc_inc, pc_in
  );
endinterface

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate of each input, add or and, optional
// negate of the result; carry discarded.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? 16'h0000 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? 16'h0000 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control: fetch/execute FSM with stalling memory read and write phases,
// A/D registers, and one pc load-or-increment pulse per instruction.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  hack_cpu_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] opnd_q, opnd_d;
  logic        opnd_vld_q, opnd_vld_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] out_q, out_d;
  logic [15:0] tgt_q, tgt_d;
  logic        jmp_q, jmp_d;

  logic        is_c, a_sel, taken;
  logic [5:0]  comp;
  logic [2:0]  dest, jump;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        load_raw, inc_raw;

  assign is_c  = ir_q[InstrTypeBit];
  assign a_sel = ir_q[ABit];
  assign comp  = ir_q[CompMsb:CompLsb];
  assign dest  = ir_q[DestMsb:DestLsb];
  assign jump  = ir_q[JumpMsb:JumpLsb];

  hack_alu u_alu (
    .x  (d_q),
    .y  (a_sel ? opnd_q : a_q),
    .zx (comp[5]),
    .nx (comp[4]),
    .zy (comp[3]),
    .ny (comp[2]),
    .f  (comp[1]),
    .no (comp[0]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  assign taken = jump_taken(jump, alu_ng, alu_zr);

  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    a_d             = a_q;
    d_d             = d_q;
    opnd_d          = opnd_q;
    opnd_vld_d      = opnd_vld_q;
    addr_d          = addr_q;
    out_d           = out_q;
    tgt_d           = tgt_q;
    jmp_d           = jmp_q;
    load_raw        = 1'b0;
    inc_raw         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.readM       = 1'b0;
    bus.writeM      = 1'b0;
    bus.pc_in       = a_q;

    case (state_q)
      StFetch: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          ir_d       = bus.instr;
          opnd_vld_d = 1'b0;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (!is_c) begin
          a_d     = ir_q;
          inc_raw = 1'b1;
          state_d = StFetch;
        end else if (a_sel && !opnd_vld_q) begin
          addr_d  = a_q[14:0];
          state_d = StMemRd;
        end else begin
          // All results and the jump target come from the pre-instruction A and D
          if (dest[DestD]) d_d = alu_out;
          if (dest[DestA]) a_d = alu_out;
          addr_d = a_q[14:0];
          out_d  = alu_out;
          if (dest[DestM]) begin
            jmp_d   = taken;
            tgt_d   = a_q;
            state_d = StMemWr;
          end else begin
            load_raw = taken;
            inc_raw  = ~taken;
            state_d  = StFetch;
          end
        end
      end
      StMemRd: begin
        bus.readM = 1'b1;
        if (bus.mem_ready) begin
          opnd_d     = bus.inM;
          opnd_vld_d = 1'b1;
          state_d    = StExec;
        end
      end
      StMemWr: begin
        bus.writeM = 1'b1;
        bus.pc_in  = tgt_q;
        if (bus.mem_ready) begin
          load_raw = jmp_q;
          inc_raw  = ~jmp_q;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // A reset cycle aborts the instruction, so its pc pulse must not escape
  assign bus.pc_load  = load_raw & ~reset;
  assign bus.pc_inc   = inc_raw & ~reset;
  assign bus.addressM = addr_q;
  assign bus.outM     = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      ir_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      opnd_q     <= '0;
      opnd_vld_q <= 1'b0;
      addr_q     <= '0;
      out_q      <= '0;
      tgt_q      <= '0;
      jmp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      d_q        <= d_d;
      opnd_q     <= opnd_d;
      opnd_vld_q <= opnd_vld_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      tgt_q      <= tgt_d;
      jmp_q      <= jmp_d;
    end
  end

endmodule

// File: doc/hack_cpu_ctrl.md
HACK_CPU_CTRL -- requirements
Module: hack_cpu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on posedge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset; the program counter (pc) shares this reset.
REQ-003 SHALL have: instr  in  16  instruction word from ROM at the current pc.
REQ-004 SHALL have: instr_valid  in  1  ROM word valid; instr_ready  out  1  fetch handshake.
REQ-005 SHALL have: inM  in  16  data-memory read data; mem_ready  in  1  memory access complete.
REQ-006 SHALL have: addressM  out  15  data address; outM  out  16  write data; writeM  out  1  write request; readM  out  1  read request.
REQ-007 SHALL have: pc_load  out  1, pc_inc  out  1, pc_in  out  16  pc control (pc priority is reset > load > inc).

Function
REQ-008 SHALL implement a four-state FSM: FETCH, EXEC, MEM_RD, MEM_WR.
REQ-009 FETCH: instr_ready=1. On instr_valid=1 the block latches instr into IR and goes to EXEC. Otherwise it stays in FETCH.
REQ-010 A-instruction (IR[15]=0), EXEC: A<=IR; pc_inc=1 for one cycle; next state FETCH. Latency is 2 cycles.
REQ-011 C-instruction fields:
 - a=IR[12]
 - comp=IR[11:6]
 - dest=IR[5:3] (A,D,M)
 - jump=IR[2:0] (lt,eq,gt)
 - IR[14:13] ignored.
REQ-012 C-instruction with a=1, first EXEC entry: go to MEM_RD without updating registers.
REQ-013 MEM_RD: readM=1 and addressM=A[14:0] are held until mem_ready=1. On that cycle inM is captured into the operand register and the FSM returns to EXEC.
REQ-014 C-instruction EXEC (operand ready): compute ALU(D, a?operand:A, comp). The following are all evaluated from pre-instruction A and D values:
 - write D if dest[1]
 - write A if dest[2]
 - latch addressM=A_old[14:0]
 - latch outM=alu result
REQ-015 Jump is taken when one of these holds:
 - (jump[2] and ng)
 - (jump[1] and zr)
 - (jump[0] and !ng and !zr)
 jump=3'b111 is unconditional.
REQ-016 Taken jump: pc_load=1 and pc_in=A_old. Not taken: pc_inc=1.
REQ-017 If dest[0]=0, the pc pulse is issued in EXEC and the next state is FETCH. If dest[0]=1, the next state is MEM_WR and the pc pulse is deferred.
REQ-018 MEM_WR: writeM=1, with addressM and outM held stable, until mem_ready=1. On the mem_ready cycle the block issues the deferred pc pulse and goes to FETCH.
REQ-019 Exactly one of pc_load/pc_inc SHALL pulse per instruction, for exactly one cycle. They are never both high.
REQ-020 readM and writeM SHALL never be high together. Both are low outside MEM_RD and MEM_WR respectively.
REQ-021 ALU arithmetic is 16-bit two's complement with carry discarded. ng=result[15]; zr=(result==0).
REQ-022 Memory waits are unbounded: mem_ready may stay low indefinitely. mem_ready is ignored outside MEM_RD and MEM_WR.

Reset
REQ-023 When reset=1 the block SHALL, at the next posedge:
 - set state to FETCH
 - set A, D, IR, operand, addressM and outM to 0
 - force writeM, readM, pc_load and pc_inc to 0
REQ-024 Reset mid-operation (any state) SHALL abort the instruction: no pc pulse, no register write, and writeM low from the next cycle.
REQ-025 In the first cycle after reset deasserts, the block SHALL be in FETCH with instr_ready=1.

Structure
REQ-026 A shared package hack_pkg SHALL hold:
 - state encodings
 - instruction field bit positions
 - comp opcode constants
 - dest/jump bit indices
REQ-027 The ALU SHALL be a separate sub-module hack_alu with ports (x, y, zx, nx, zy, ny, f, no, out, zr, ng). It is purely combinational. All registers and the FSM live in hack_cpu_ctrl.

Verification
REQ-028 Instruction @7 (16'h0007), instr_valid=1 -> A=7 after EXEC; one pc_inc pulse; 2 cycles total.
REQ-029 @5, then D=A (16'hEC10), then D;JGT (16'hE301) -> D=5; pc_load=1 with pc_in=5.
REQ-030 A=100, M=D+1 (16'hE7C8) with D=9 and mem_ready delayed 3 cycles -> the following are held for 4 cycles:
 - writeM=1
 - addressM=100
 - outM=10
 Then one pc_inc pulse.
REQ-031 A=3, inM=16'hFFFF, D=M;JLT (16'hFC14) -> readM until mem_ready; D=16'hFFFF; pc_load with pc_in=3.
REQ-032 AM=M-1 with A=20, inM=1 (16'hFCA8) -> write to address 20 of outM=0; A=0 afterwards; pc_inc pulse after the write completes.
REQ-033 reset asserted in MEM_WR while mem_ready=0 -> writeM=0 next cycle; no pc pulse; A=D=0; state FETCH.
